// File: rtl/mem_port_arbiter.sv
// Purpose : round-robin arbiter sharing one two-port synchronous memory among NREQ requesters.
// Latency : grant and memory command are combinational; read data returns 1 cycle after grant.
// Backpres: a requester holds its request until reqGrant; same-address write conflicts defer B.
//
// Ports: clock/resetN (async active-low); reqValid/reqWrite/reqAddr/reqWdata per requester,
// reqGrant back to requesters; rspValid/rspData read returns; memWe/memAddr/memWdata 0/1 drive
// the memory ports and memRdata 0/1 come back from it; conflictCount counts deferrals (saturating).
module mem_port_arbiter #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic [NREQ-1:0]         reqValid,
    input  logic [NREQ-1:0]         reqWrite,
    input  logic [NREQ*DEPTH-1:0]   reqAddr,
    input  logic [NREQ*WIDTH-1:0]   reqWdata,
    output logic [NREQ-1:0]         reqGrant,
    output logic [NREQ-1:0]         rspValid,
    output logic [NREQ*WIDTH-1:0]   rspData,
    output logic                    memWe0,
    output logic [DEPTH-1:0]        memAddr0,
    output logic [WIDTH-1:0]        memWdata0,
    input  logic [WIDTH-1:0]        memRdata0,
    output logic                    memWe1,
    output logic [DEPTH-1:0]        memAddr1,
    output logic [WIDTH-1:0]        memWdata1,
    input  logic [WIDTH-1:0]        memRdata1,
    output logic [7:0]              conflictCount
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    rr_ptr;
    logic             pend0, pend1;
    logic [PW-1:0]    owner0, owner1;
    logic [7:0]       conflict_cnt;

    logic             a_vld, b_vld;
    logic [PW-1:0]    a_idx, b_idx;
    logic [PW:0]      scan_sum;
    logic [PW-1:0]    scan_idx;
    logic [DEPTH-1:0] a_addr, b_addr;
    logic [WIDTH-1:0] a_wdat, b_wdat;
    logic             a_wr, b_wr;
    logic             conflict;
    logic             gnt_a, gnt_b;

    // Round-robin scan starting at rr_ptr: first valid index is A (port 0), next is B (port 1).
    always_comb begin
        a_vld    = 1'b0;
        b_vld    = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NREQ))
                scan_sum = scan_sum - (PW+1)'(NREQ);
            scan_idx = scan_sum[PW-1:0];
            if (reqValid[scan_idx]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = scan_idx;
                end else if (!b_vld) begin
                    b_vld = 1'b1;
                    b_idx = scan_idx;
                end
            end
        end
    end

    assign a_addr = reqAddr[int'(a_idx)*DEPTH +: DEPTH];
    assign b_addr = reqAddr[int'(b_idx)*DEPTH +: DEPTH];
    assign a_wdat = reqWdata[int'(a_idx)*WIDTH +: WIDTH];
    assign b_wdat = reqWdata[int'(b_idx)*WIDTH +: WIDTH];
    assign a_wr   = reqWrite[a_idx];
    assign b_wr   = reqWrite[b_idx];

    // Same address with any write in the pair would make port ordering ambiguous; B waits.
    assign conflict = a_vld && b_vld && (a_addr == b_addr) && (a_wr || b_wr);

    // Grants are gated by resetN so nothing is accepted while reset is held.
    assign gnt_a = a_vld && resetN;
    assign gnt_b = b_vld && !conflict && resetN;

    always_comb begin
        reqGrant = '0;
        if (gnt_a) reqGrant[a_idx] = 1'b1;
        if (gnt_b) reqGrant[b_idx] = 1'b1;
    end

    assign memWe0    = gnt_a && a_wr;
    assign memAddr0  = gnt_a ? a_addr : '0;
    assign memWdata0 = (gnt_a && a_wr) ? a_wdat : '0;
    assign memWe1    = gnt_b && b_wr;
    assign memAddr1  = gnt_b ? b_addr : '0;
    assign memWdata1 = (gnt_b && b_wr) ? b_wdat : '0;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rr_ptr       <= '0;
            pend0        <= 1'b0;
            pend1        <= 1'b0;
            owner0       <= '0;
            owner1       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt_b)
                rr_ptr <= next_idx(b_idx);
            else if (gnt_a)
                rr_ptr <= next_idx(a_idx);

            pend0 <= gnt_a && !a_wr;
            pend1 <= gnt_b && !b_wr;
            if (gnt_a && !a_wr) owner0 <= a_idx;
            if (gnt_b && !b_wr) owner1 <= b_idx;

            if (conflict && conflict_cnt != 8'hFF)
                conflict_cnt <= conflict_cnt + 8'd1;
        end
    end

    // Pending flags mark which port's registered read data belongs to whom this cycle.
    always_comb begin
        rspValid = '0;
        rspData  = '0;
        if (pend0) begin
            rspValid[owner0]                      = 1'b1;
            rspData[int'(owner0)*WIDTH +: WIDTH]  = memRdata0;
        end
        if (pend1) begin
            rspValid[owner1]                      = 1'b1;
            rspData[int'(owner1)*WIDTH +: WIDTH]  = memRdata1;
        end
    end

    assign conflictCount = conflict_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter with a behavioural two-port memory.
// Latency : responses expected exactly one cycle after a read grant.
// Backpres: requests are held or dropped by the directed sequence below.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        resetN;
    logic [3:0]  reqValid, reqWrite, reqGrant, rspValid;
    logic [15:0] reqAddr, reqWdata, rspData;
    logic        memWe0, memWe1;
    logic [3:0]  memAddr0, memAddr1, memWdata0, memWdata1;
    logic [3:0]  memRdata0, memRdata1;
    logic [7:0]  conflictCount;

    // Second instance with three requesters, used only for grant-pattern checks.
    logic [2:0]  v3, gnt3, rspv3;
    logic [11:0] rspd3;
    logic        we30, we31;
    logic [3:0]  a30, a31, d30, d31;
    logic [7:0]  cc3;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct { int cyc; logic [3:0] data; } exp_t;
    exp_t expq[4][$];

    logic [3:0] mem [16];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_port_arbiter #(.NREQ(4), .DEPTH(4), .WIDTH(4)) u_dut (
        .clock(clock), .resetN(resetN),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWdata(reqWdata),
        .reqGrant(reqGrant), .rspValid(rspValid), .rspData(rspData),
        .memWe0(memWe0), .memAddr0(memAddr0), .memWdata0(memWdata0), .memRdata0(memRdata0),
        .memWe1(memWe1), .memAddr1(memAddr1), .memWdata1(memWdata1), .memRdata1(memRdata1),
        .conflictCount(conflictCount)
    );

    mem_port_arbiter #(.NREQ(3), .DEPTH(4), .WIDTH(4)) u_dut3 (
        .clock(clock), .resetN(resetN),
        .reqValid(v3), .reqWrite(3'b000), .reqAddr(12'h210), .reqWdata(12'h000),
        .reqGrant(gnt3), .rspValid(rspv3), .rspData(rspd3),
        .memWe0(we30), .memAddr0(a30), .memWdata0(d30), .memRdata0(4'h0),
        .memWe1(we31), .memAddr1(a31), .memWdata1(d31), .memRdata1(4'h0),
        .conflictCount(cc3)
    );

    // Two-port memory: registered read data, no read update on a write cycle.
    initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    always @(posedge clock) begin
        if (memWe0) mem[memAddr0] <= memWdata0; else memRdata0 <= mem[memAddr0];
        if (memWe1) mem[memAddr1] <= memWdata1; else memRdata1 <= mem[memAddr1];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic setr(input int i, input bit w, input int a, input int d);
        reqValid[i]         = 1'b1;
        reqWrite[i]         = w;
        reqAddr[i*4 +: 4]   = 4'(a);
        reqWdata[i*4 +: 4]  = 4'(d);
    endtask

    task automatic clr();
        reqValid = '0; reqWrite = '0; reqAddr = '0; reqWdata = '0;
    endtask

    task automatic expect_rd(input int i, input int d);
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = 4'(d);
        expq[i].push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clock) begin
        logic [15:0] idle_mask;
        idle_mask = '0;
        for (int i = 0; i < 4; i++) begin
            if (rspValid[i]) begin
                checks++;
                if (expq[i].size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected r%0d: got data %0h expected no response (cycle %0d)",
                             i, rspData[i*4 +: 4], cyc);
                end else begin
                    exp_t e;
                    e = expq[i].pop_front();
                    if (e.cyc != cyc || rspData[i*4 +: 4] !== e.data) begin
                        errors++;
                        $display("FAIL rsp_r%0d: got data %0h at cycle %0d expected %0h at cycle %0d",
                                 i, rspData[i*4 +: 4], cyc, e.data, e.cyc);
                    end
                end
            end else begin
                idle_mask[i*4 +: 4] = 4'hF;
            end
        end
        chk("rsp_idle_zero", 32'(rspData & idle_mask), 32'h0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] fair_dat [4];
        fair_dat[0] = 4'h5; fair_dat[1] = 4'hC; fair_dat[2] = 4'hA; fair_dat[3] = 4'h3;
        resetN = 1'b0;
        v3 = '0;
        clr();
        for (int i = 0; i < 4; i++) setr(i, 1'b0, 8 + i, 0);

        // Reset held with every requester asking.
        @(negedge clock);
        chk("rst_grant", 32'(reqGrant), 32'h0);
        chk("rst_we", 32'({memWe0, memWe1}), 32'h0);
        chk("rst_rspvalid", 32'(rspValid), 32'h0);
        chk("rst_conflict", 32'(conflictCount), 32'h0);
        next_cycle();
        resetN = 1'b1;
        @(negedge clock);
        chk("release_grant", 32'(reqGrant), 32'h3);
        expect_rd(0, 0); expect_rd(1, 0);
        next_cycle(); clr();

        // Write then read back (rrPtr=2).
        setr(0, 1'b1, 3, 'hA);
        @(negedge clock);
        chk("wr_grant", 32'(reqGrant), 32'h1);
        chk("wr_we0", 32'(memWe0), 32'h1);
        chk("wr_addr0", 32'(memAddr0), 32'h3);
        chk("wr_wdata0", 32'(memWdata0), 32'hA);
        chk("wr_we1_idle", 32'({memWe1, memAddr1, memWdata1}), 32'h0);
        next_cycle(); clr();
        setr(0, 1'b0, 3, 0);
        @(negedge clock);
        chk("rd_grant", 32'(reqGrant), 32'h1);
        chk("rd_we0", 32'(memWe0), 32'h0);
        expect_rd(0, 'hA);
        next_cycle(); clr();

        // Dual write then dual read.
        setr(1, 1'b1, 2, 'h5); setr(2, 1'b1, 5, 'hC);
        @(negedge clock);
        chk("dwr_grant", 32'(reqGrant), 32'h6);
        chk("dwr_we", 32'({memWe0, memWe1}), 32'h3);
        chk("dwr_addr", 32'({memAddr0, memAddr1}), 32'h25);
        next_cycle(); clr();
        setr(1, 1'b0, 2, 0); setr(2, 1'b0, 5, 0);
        @(negedge clock);
        chk("drd_grant", 32'(reqGrant), 32'h6);
        chk("drd_addr", 32'({memAddr0, memAddr1}), 32'h25);
        expect_rd(1, 'h5); expect_rd(2, 'hC);
        next_cycle(); clr();

        // Single read from r3 brings rrPtr back to 0.
        setr(3, 1'b0, 5, 0);
        @(negedge clock);
        chk("r3_grant", 32'(reqGrant), 32'h8);
        expect_rd(3, 'hC);
        next_cycle(); clr();

        // Conflict: r0 write and r3 read to addr 7.
        setr(0, 1'b1, 7, 'h3); setr(3, 1'b0, 7, 0);
        @(negedge clock);
        chk("cfl_grant", 32'(reqGrant), 32'h1);
        chk("cfl_port1_idle", 32'({memWe1, memAddr1}), 32'h0);
        next_cycle();
        reqValid[0] = 1'b0;
        @(negedge clock);
        chk("cfl_count", 32'(conflictCount), 32'h1);
        chk("cfl_retry_grant", 32'(reqGrant), 32'h8);
        chk("cfl_retry_addr0", 32'({memWe0, memAddr0}), 32'h7);
        expect_rd(3, 'h3);
        next_cycle(); clr();

        // Fairness: all four read distinct addresses continuously.
        setr(0, 1'b0, 2, 0); setr(1, 1'b0, 5, 0); setr(2, 1'b0, 3, 0); setr(3, 1'b0, 7, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("fair_grant", 32'(reqGrant), (c % 2 == 0) ? 32'h3 : 32'hC);
            for (int i = 0; i < 4; i++)
                if ((i / 2) == (c % 2)) expect_rd(i, fair_dat[i]);
            next_cycle();
        end
        clr();

        // Two reads to the same address: both granted, no conflict counted.
        setr(0, 1'b0, 3, 0); setr(1, 1'b0, 3, 0);
        @(negedge clock);
        chk("same_rd_grant", 32'(reqGrant), 32'h3);
        expect_rd(0, 'hA); expect_rd(1, 'hA);
        next_cycle(); clr();
        @(negedge clock);
        chk("same_rd_count", 32'(conflictCount), 32'h1);
        next_cycle();

        // Reset between a read grant and its response.
        setr(2, 1'b0, 5, 0);
        @(negedge clock);
        chk("rstmid_grant", 32'(reqGrant), 32'h4);
        next_cycle();
        resetN = 1'b0; clr();
        @(negedge clock);
        chk("rstmid_rspvalid", 32'(rspValid), 32'h0);
        next_cycle();
        resetN = 1'b1;
        setr(1, 1'b0, 2, 0); setr(2, 1'b0, 3, 0); setr(3, 1'b0, 7, 0);
        @(negedge clock);
        chk("rstmid_ptr_grant", 32'(reqGrant), 32'h6);
        chk("rstmid_count", 32'(conflictCount), 32'h0);
        expect_rd(1, 'h5); expect_rd(2, 'hA);
        next_cycle(); clr();

        // NREQ=3: grant pairs {0,1}, {2,0}, {1,2}.
        v3 = 3'b111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("n3_grant", 32'(gnt3), (c == 0) ? 32'h3 : (c == 1) ? 32'h5 : 32'h6);
            next_cycle();
        end
        v3 = '0;

        repeat (3) next_cycle();
        for (int i = 0; i < 4; i++) chk("rsp_missing", 32'(expq[i].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
